// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control sequencer.
package mc_pkg;

  // Sequencer states; the numeric encoding is visible on the debug port.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    LDI      = 4'd11,
    HALT     = 4'd12,
    FAULT    = 4'd13
  } stateT;

  // Opcode classes, taken from opcode[5:4].
  localparam logic [1:0] CLASS_RALU = 2'b00;
  localparam logic [1:0] CLASS_IALU = 2'b01;
  localparam logic [1:0] CLASS_MEM  = 2'b10;
  localparam logic [1:0] CLASS_CTRL = 2'b11;

  // Fully decoded opcodes of the memory and control classes.
  localparam logic [5:0] OP_LOAD  = 6'b10_0000;
  localparam logic [5:0] OP_STORE = 6'b10_0001;
  localparam logic [5:0] OP_LDI   = 6'b10_0010;
  localparam logic [5:0] OP_BEQ   = 6'b11_0000;
  localparam logic [5:0] OP_BNE   = 6'b11_0001;
  localparam logic [5:0] OP_JMP   = 6'b11_0010;
  localparam logic [5:0] OP_HALT  = 6'b11_1111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_BUSB  = 2'd0;
  localparam logic [1:0] ALUB_ONE   = 2'd1;
  localparam logic [1:0] ALUB_SEXT  = 2'd2;
  localparam logic [1:0] ALUB_SHIFT = 2'd3;

  localparam logic [1:0] WD_MDR    = 2'd0;
  localparam logic [1:0] WD_ALUOUT = 2'd1;
  localparam logic [1:0] WD_IMM    = 2'd2;

  // All datapath strobes and selects except the parameter-width ALU op.
  typedef struct packed {
    logic       pcLoad;
    logic       memAddrSel;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       mdrWrite;
    logic       regWrite;
    logic [1:0] regWriteDataSel;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       regTrackSelect;
    logic       retire;
  } ctrlT;

  // States that hold a RAM request open and therefore wait on mem_ready.
  function automatic logic isMemState(input stateT s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; flags expiry once MEM_TIMEOUT waits have elapsed.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] waitCnt;

  // Count waiting cycles, saturating at the timeout value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      waitCnt <= '0;
    end else if (enable && !expired) begin
      waitCnt <= waitCnt + CW'(1);
    end
  end

  assign expired = (waitCnt == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_control_seq.sv
// Multicycle core control sequencer: state machine plus control decode.
// RAM handshake: mem_read/mem_write act as valid and mem_ready as ready; a
// request and its mem_addr_sel stay stable until the cycle mem_ready is high,
// which completes the transfer. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
module mc_control_seq
  import mc_pkg::*;
#(
  parameter int OP_SIZE     = 6,
  parameter int ALU_OP_SIZE = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   mem_ready,
  input  logic                   alu_zero,
  output logic                   pc_load,
  output logic                   mem_addr_sel,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mdr_write,
  output logic                   reg_write,
  output logic [1:0]             reg_write_data_sel,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALU_OP_SIZE-1:0] alu_op,
  output logic [1:0]             pc_src,
  output logic                   reg_track_select,
  output logic                   retire,
  output logic [3:0]             state,
  output logic                   fault
);

  localparam logic [ALU_OP_SIZE-1:0] ALU_ADD_W = ALU_OP_SIZE'(ALU_ADD);
  localparam logic [ALU_OP_SIZE-1:0] ALU_SUB_W = ALU_OP_SIZE'(ALU_SUB);

  stateT                  stateQ, stateD;
  ctrlT                   ctrl;
  logic [ALU_OP_SIZE-1:0] aluOpSel;
  logic [5:0]             op6;
  logic [1:0]             opClass;
  logic                   inMem, timerExpired, timeout;

  assign op6     = opcode[5:0];
  assign opClass = opcode[5:4];
  assign inMem   = isMemState(stateQ);
  assign timeout = inMem && !mem_ready && timerExpired;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uWaitTimer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!inMem || mem_ready),
    .enable  (inMem && !mem_ready),
    .expired (timerExpired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) stateQ <= FETCH;
    else       stateQ <= stateD;
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      FETCH:    if (mem_ready) stateD = DECODE; else if (timeout) stateD = FAULT;
      DECODE: begin
        case (opClass)
          CLASS_RALU: stateD = EXEC_R;
          CLASS_IALU: stateD = EXEC_I;
          CLASS_MEM: begin
            if (op6 == OP_LOAD || op6 == OP_STORE) stateD = MEM_ADDR;
            else if (op6 == OP_LDI)                stateD = LDI;
            else                                   stateD = FAULT;
          end
          default: begin
            if (op6 == OP_BEQ || op6 == OP_BNE) stateD = BRANCH;
            else if (op6 == OP_JMP)             stateD = JUMP;
            else if (op6 == OP_HALT)            stateD = HALT;
            else                                stateD = FAULT;
          end
        endcase
      end
      EXEC_R, EXEC_I: stateD = WB_ALU;
      MEM_ADDR: stateD = (op6 == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) stateD = WB_MEM; else if (timeout) stateD = FAULT;
      MEM_WR:   if (mem_ready) stateD = FETCH;  else if (timeout) stateD = FAULT;
      WB_ALU, WB_MEM, LDI, BRANCH, JUMP: stateD = FETCH;
      HALT:     stateD = HALT;
      FAULT:    stateD = FAULT;
      default:  stateD = FAULT;
    endcase
  end

  // Output decode per state; everything is forced low while reset is high.
  always_comb begin
    ctrl     = '0;
    aluOpSel = ALU_ADD_W;
    case (stateQ)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = ALUB_ONE;
        ctrl.pcSrc   = PC_SRC_ALU;
        ctrl.irWrite = mem_ready;
        ctrl.pcLoad  = mem_ready;
      end
      DECODE: ctrl.aluSrcB = ALUB_SHIFT;
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUB_BUSB;
        aluOpSel     = ALU_OP_SIZE'(opcode[3:0]);
      end
      EXEC_I: begin
        ctrl.aluSrcA        = 1'b1;
        ctrl.aluSrcB        = ALUB_SEXT;
        ctrl.regTrackSelect = 1'b1;
        aluOpSel            = ALU_OP_SIZE'(opcode[3:0]);
      end
      WB_ALU: begin
        ctrl.regWrite        = 1'b1;
        ctrl.regWriteDataSel = WD_ALUOUT;
        ctrl.retire          = 1'b1;
      end
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUB_SEXT;
      end
      MEM_RD: begin
        ctrl.memAddrSel = 1'b1;
        ctrl.memRead    = 1'b1;
        ctrl.mdrWrite   = mem_ready;
      end
      WB_MEM: begin
        ctrl.regWrite        = 1'b1;
        ctrl.regWriteDataSel = WD_MDR;
        ctrl.retire          = 1'b1;
      end
      MEM_WR: begin
        ctrl.memAddrSel = 1'b1;
        ctrl.memWrite   = 1'b1;
        ctrl.retire     = mem_ready;
      end
      LDI: begin
        ctrl.regWrite        = 1'b1;
        ctrl.regWriteDataSel = WD_IMM;
        ctrl.regTrackSelect  = 1'b1;
        ctrl.retire          = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUB_BUSB;
        ctrl.pcSrc   = PC_SRC_ALUOUT;
        ctrl.pcLoad  = (op6 == OP_BNE) ? !alu_zero : alu_zero;
        ctrl.retire  = 1'b1;
        aluOpSel     = ALU_SUB_W;
      end
      JUMP: begin
        ctrl.pcSrc  = PC_SRC_JUMP;
        ctrl.pcLoad = 1'b1;
        ctrl.retire = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ctrl     = '0;
      aluOpSel = '0;
    end
  end

  assign pc_load            = ctrl.pcLoad;
  assign mem_addr_sel       = ctrl.memAddrSel;
  assign mem_read           = ctrl.memRead;
  assign mem_write          = ctrl.memWrite;
  assign ir_write           = ctrl.irWrite;
  assign mdr_write          = ctrl.mdrWrite;
  assign reg_write          = ctrl.regWrite;
  assign reg_write_data_sel = ctrl.regWriteDataSel;
  assign alu_src_a          = ctrl.aluSrcA;
  assign alu_src_b          = ctrl.aluSrcB;
  assign alu_op             = aluOpSel;
  assign pc_src             = ctrl.pcSrc;
  assign reg_track_select   = ctrl.regTrackSelect;
  assign retire             = ctrl.retire;
  assign state              = reset ? 4'd0 : stateQ;
  assign fault              = !reset && (stateQ == FAULT);

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed bench for mc_control_seq: per-cycle vector table plus corner sequences.
module tb_mc_control_seq;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;

  localparam logic [5:0] OP_R     = 6'b00_0010;
  localparam logic [5:0] OP_I     = 6'b01_0101;
  localparam logic [5:0] OP_LOAD  = 6'b10_0000;
  localparam logic [5:0] OP_STORE = 6'b10_0001;
  localparam logic [5:0] OP_LDI   = 6'b10_0010;
  localparam logic [5:0] OP_BAD   = 6'b10_0111;
  localparam logic [5:0] OP_BEQ   = 6'b11_0000;
  localparam logic [5:0] OP_BNE   = 6'b11_0001;
  localparam logic [5:0] OP_JMP   = 6'b11_0010;
  localparam logic [5:0] OP_HALT  = 6'b11_1111;

  logic       clk, reset, mem_ready, alu_zero;
  logic [5:0] opcode;
  logic       pc_load, mem_addr_sel, mem_read, mem_write, ir_write, mdr_write, reg_write;
  logic [1:0] reg_write_data_sel, alu_src_b, pc_src;
  logic       alu_src_a, reg_track_select, retire, fault;
  logic [3:0] alu_op, state;
  logic [24:0] actual;

  int assertCount = 0;
  int failCount   = 0;

  mc_control_seq #(.OP_SIZE(6), .ALU_OP_SIZE(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .pc_load(pc_load), .mem_addr_sel(mem_addr_sel), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .reg_write(reg_write),
    .reg_write_data_sel(reg_write_data_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .reg_track_select(reg_track_select), .retire(retire),
    .state(state), .fault(fault)
  );

  assign actual = {state, pc_load, mem_addr_sel, mem_read, mem_write, ir_write, mdr_write,
                   reg_write, reg_write_data_sel, alu_src_a, alu_src_b, alu_op, pc_src,
                   reg_track_select, retire, fault};

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output bundle, same field order as 'actual'.
  function automatic logic [24:0] ex(input logic [3:0] st, input logic pcl, mas, mr, mw, irw,
                                     mdrw, rw, input logic [1:0] wds, input logic sa,
                                     input logic [1:0] sb, input logic [3:0] aop,
                                     input logic [1:0] ps, input logic rts, ret, flt);
    return {st, pcl, mas, mr, mw, irw, mdrw, rw, wds, sa, sb, aop, ps, rts, ret, flt};
  endfunction

  task automatic checkBundle(input string name, input logic [24:0] exp);
    assertCount++;
    if (actual !== exp) begin
      failCount++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               name, actual, actual[24:21], exp, exp[24:21]);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic        az;
    logic [24:0] exp;
  } vecT;

  vecT vecs[$];

  task automatic add(input string n, input logic r, input logic [5:0] o, input logic rd,
                     input logic a, input logic [24:0] e);
    vecs.push_back('{n, r, o, rd, a, e});
  endtask

  logic [24:0] eFetch, eFetchWait, eDecode, eWbAlu, eMemAddr, eZero;
  logic        rdyPat[8];
  int          rdCnt, mdrCnt, mdrCyc, retCnt, fetchCnt;

  initial begin
    reset = 1'b1; opcode = '0; mem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    eZero      = '0;
    eFetch     = ex(4'd0, H,L,H,L,H,L,L, 2'd0, L, 2'd1, ADD, 2'd0, L,L,L);
    eFetchWait = ex(4'd0, L,L,H,L,L,L,L, 2'd0, L, 2'd1, ADD, 2'd0, L,L,L);
    eDecode    = ex(4'd1, L,L,L,L,L,L,L, 2'd0, L, 2'd3, ADD, 2'd0, L,L,L);
    eWbAlu     = ex(4'd7, L,L,L,L,L,L,H, 2'd1, L, 2'd0, ADD, 2'd0, L,H,L);
    eMemAddr   = ex(4'd4, L,L,L,L,L,L,L, 2'd0, H, 2'd2, ADD, 2'd0, L,L,L);

    // Zero-wait instruction table
    add("reset",     H, OP_R, H, L, eZero);
    add("r_fetch",   L, OP_R, H, L, eFetch);
    add("r_decode",  L, OP_R, H, L, eDecode);
    add("r_exec",    L, OP_R, H, L, ex(4'd2, L,L,L,L,L,L,L, 2'd0, H, 2'd0, 4'd2, 2'd0, L,L,L));
    add("r_wb",      L, OP_R, H, L, eWbAlu);
    add("i_fetch",   L, OP_I, H, L, eFetch);
    add("i_decode",  L, OP_I, H, L, eDecode);
    add("i_exec",    L, OP_I, H, L, ex(4'd3, L,L,L,L,L,L,L, 2'd0, H, 2'd2, 4'd5, 2'd0, H,L,L));
    add("i_wb",      L, OP_I, H, L, eWbAlu);
    add("ldi_fetch", L, OP_LDI, H, L, eFetch);
    add("ldi_dec",   L, OP_LDI, H, L, eDecode);
    add("ldi_wb",    L, OP_LDI, H, L, ex(4'd11, L,L,L,L,L,L,H, 2'd2, L, 2'd0, ADD, 2'd0, H,H,L));
    add("st_fetch",  L, OP_STORE, H, L, eFetch);
    add("st_dec",    L, OP_STORE, H, L, eDecode);
    add("st_addr",   L, OP_STORE, H, L, eMemAddr);
    add("st_wr",     L, OP_STORE, H, L, ex(4'd6, L,H,L,H,L,L,L, 2'd0, L, 2'd0, ADD, 2'd0, L,H,L));
    add("ld_fetch",  L, OP_LOAD, H, L, eFetch);
    add("ld_dec",    L, OP_LOAD, H, L, eDecode);
    add("ld_addr",   L, OP_LOAD, H, L, eMemAddr);
    add("ld_rd",     L, OP_LOAD, H, L, ex(4'd5, L,H,H,L,L,H,L, 2'd0, L, 2'd0, ADD, 2'd0, L,L,L));
    add("ld_wb",     L, OP_LOAD, H, L, ex(4'd8, L,L,L,L,L,L,H, 2'd0, L, 2'd0, ADD, 2'd0, L,H,L));
    add("beq1_fetch",L, OP_BEQ, H, H, eFetch);
    add("beq1_dec",  L, OP_BEQ, H, H, eDecode);
    add("beq1_br",   L, OP_BEQ, H, H, ex(4'd9, H,L,L,L,L,L,L, 2'd0, H, 2'd0, SUB, 2'd1, L,H,L));
    add("beq0_fetch",L, OP_BEQ, H, L, eFetch);
    add("beq0_dec",  L, OP_BEQ, H, L, eDecode);
    add("beq0_br",   L, OP_BEQ, H, L, ex(4'd9, L,L,L,L,L,L,L, 2'd0, H, 2'd0, SUB, 2'd1, L,H,L));
    add("bne1_fetch",L, OP_BNE, H, H, eFetch);
    add("bne1_dec",  L, OP_BNE, H, H, eDecode);
    add("bne1_br",   L, OP_BNE, H, H, ex(4'd9, L,L,L,L,L,L,L, 2'd0, H, 2'd0, SUB, 2'd1, L,H,L));
    add("bne0_fetch",L, OP_BNE, H, L, eFetch);
    add("bne0_dec",  L, OP_BNE, H, L, eDecode);
    add("bne0_br",   L, OP_BNE, H, L, ex(4'd9, H,L,L,L,L,L,L, 2'd0, H, 2'd0, SUB, 2'd1, L,H,L));
    add("jmp_fetch", L, OP_JMP, H, L, eFetch);
    add("jmp_dec",   L, OP_JMP, H, L, eDecode);
    add("jmp_jump",  L, OP_JMP, H, L, ex(4'd10, H,L,L,L,L,L,L, 2'd0, L, 2'd0, ADD, 2'd2, L,H,L));
    add("end_fetch", L, OP_R, L, L, eFetchWait);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; opcode = vecs[i].op;
      mem_ready = vecs[i].rdy; alu_zero = vecs[i].az;
      #2;
      checkBundle(vecs[i].name, vecs[i].exp);
      tick();
    end

    // LOAD with three wait cycles in MEM_RD
    doReset();
    opcode = OP_LOAD; alu_zero = 1'b0;
    rdyPat = '{H, H, H, L, L, L, H, H};
    rdCnt = 0; mdrCnt = 0; mdrCyc = -1; retCnt = 0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = rdyPat[c];
      #2;
      if (mem_read && c >= 3) rdCnt++;
      if (mdr_write) begin mdrCnt++; mdrCyc = c; end
      if (retire) retCnt++;
      tick();
    end
    #2;
    checkVal("load_wait_total", int'(state), 0);
    checkVal("load_wait_rd_cycles", rdCnt, 4);
    checkVal("load_wait_mdr_pulses", mdrCnt, 1);
    checkVal("load_wait_mdr_cycle", mdrCyc, 6);
    checkVal("load_wait_retires", retCnt, 1);

    // mem_ready on the last allowed wait cycle wins over the timeout
    doReset();
    opcode = OP_R; mem_ready = 1'b0;
    repeat (10) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    #2;
    checkVal("refetch_state", int'(state), 0);
    repeat (15) tick();
    mem_ready = 1'b1;
    #2;
    checkVal("ready_wins_irwrite", int'(ir_write), 1);
    tick();
    #2;
    checkVal("ready_wins_state", int'(state), 1);

    // Timeout in FETCH
    doReset();
    mem_ready = 1'b0; fetchCnt = 0;
    for (int c = 0; c < 16; c++) begin
      #2;
      if (state == 4'd0 && mem_read) fetchCnt++;
      tick();
    end
    #2;
    checkVal("timeout_fetch_cycles", fetchCnt, 16);
    checkBundle("timeout_fault", ex(4'd13, L,L,L,L,L,L,L, 2'd0, L, 2'd0, ADD, 2'd0, L,L,H));
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      #2;
      checkVal("fault_sticky", int'({state, fault}), 27);
    end
    reset = 1'b1;
    #2;
    checkBundle("fault_reset", eZero);
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #2;
    checkBundle("fault_cleared", eFetchWait);

    // Illegal opcode
    doReset();
    opcode = OP_BAD; mem_ready = 1'b1;
    tick();
    #2;
    checkVal("illegal_decode", int'(state), 1);
    tick();
    #2;
    checkVal("illegal_fault", int'({state, fault}), 27);

    // HALT holds with all strobes low
    doReset();
    opcode = OP_HALT; mem_ready = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      #2;
      checkBundle("halt_hold", ex(4'd12, L,L,L,L,L,L,L, 2'd0, L, 2'd0, ADD, 2'd0, L,L,L));
      tick();
    end

    // Reset during a MEM_WR wait
    doReset();
    opcode = OP_STORE; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #2;
    checkBundle("memwr_wait", ex(4'd6, L,H,L,H,L,L,L, 2'd0, L, 2'd0, ADD, 2'd0, L,L,L));
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    #2;
    checkBundle("memwr_reset_cycle", eZero);
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #2;
    checkBundle("memwr_after_reset", eFetchWait);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
